// File: rtl/nvram_upload.sv
// Host-upload responder for the ioctl interface: serves NVRAM bytes to the host,
// stretching each read with ioctl_wait and owning the RAM port while a session is open.
module nvram_upload #(
    parameter int         ADDR_W  = 10,
    parameter int         SIZE    = 1024,
    parameter int         RAM_LAT = 1,
    parameter logic [7:0] INDEX   = 8'd4
) (
    input  logic              clk_4m,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              busy,
    output logic              done,
    output logic [15:0]       byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_READ,
        S_OOR,
        S_CAP
    } state_t;

    state_t            state_q, state_d;
    logic              upload_q, upload_d;
    logic              upload_prev_q, upload_prev_d;
    logic              match_q, match_d;
    logic [1:0]        lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;

    logic              start;
    logic              in_range;
    logic              end_sess;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        upload_d      = ioctl_upload;
        upload_prev_d = upload_q;
        match_d       = (ioctl_index == INDEX);
        lat_d         = lat_q;
        din_d         = din_q;
        wait_d        = wait_q;
        ram_addr_d    = ram_addr_q;
        ram_rd_d      = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        byte_cnt_d    = byte_cnt_q;
        end_sess      = 1'b0;

        // The index is only qualified on the rising edge of the registered upload level.
        start    = upload_q && !upload_prev_q && match_q;
        in_range = (ioctl_addr < 25'(SIZE));

        case (state_q)
            S_IDLE: begin
                wait_d = 1'b0;
                if (start) begin
                    state_d    = S_ARMED;
                    busy_d     = 1'b1;
                    byte_cnt_d = 16'd0;
                end
            end
            S_ARMED, S_CAP: begin
                if (state_q == S_CAP) begin
                    din_d = ram_q;
                end
                if (!upload_q) begin
                    end_sess = 1'b1;
                end else if (ioctl_rd) begin
                    wait_d = 1'b1;
                    if (in_range) begin
                        ram_addr_d = ioctl_addr[ADDR_W-1:0];
                        ram_rd_d   = 1'b1;
                        lat_d      = 2'(RAM_LAT - 1);
                        state_d    = S_READ;
                    end else begin
                        din_d   = 8'hFF;
                        state_d = S_OOR;
                    end
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_READ: begin
                // A fall before the capture cycle abandons the RAM read entirely.
                if (!upload_q) begin
                    end_sess = 1'b1;
                end else if (lat_q == 2'd0) begin
                    wait_d     = 1'b0;
                    byte_cnt_d = sat_inc(byte_cnt_q);
                    state_d    = S_CAP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_OOR: begin
                if (!upload_q) begin
                    end_sess = 1'b1;
                end else begin
                    wait_d  = 1'b0;
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_sess) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            wait_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_4m or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            upload_q      <= 1'b0;
            upload_prev_q <= 1'b0;
            match_q       <= 1'b0;
            lat_q         <= 2'd0;
            din_q         <= 8'h00;
            wait_q        <= 1'b0;
            ram_addr_q    <= '0;
            ram_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            byte_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            upload_q      <= upload_d;
            upload_prev_q <= upload_prev_d;
            match_q       <= match_d;
            lat_q         <= lat_d;
            din_q         <= din_d;
            wait_q        <= wait_d;
            ram_addr_q    <= ram_addr_d;
            ram_rd_q      <= ram_rd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    // In the capture cycle the RAM byte is forwarded directly so it is valid as wait drops.
    assign ioctl_din  = (state_q == S_CAP) ? ram_q : din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_nvram_upload.sv
// Bench for nvram_upload: two instances (RAM_LAT=1 and RAM_LAT=3) share the host side,
// each with its own pipelined RAM model; expected bytes go through a scoreboard queue.
module tb_nvram_upload;

    logic        clk_4m;
    logic        reset;
    logic        upload;
    logic        rd;
    logic [24:0] addr;
    logic [7:0]  index;

    logic [7:0]  din   [2];
    logic        wt    [2];
    logic [9:0]  raddr [2];
    logic        rrd   [2];
    logic [7:0]  rq    [2];
    logic        bsy   [2];
    logic        dn    [2];
    logic [15:0] bcnt  [2];

    logic [7:0]  mem [1024];
    logic [7:0]  pipe0, pipe1a, pipe1b, pipe1c;

    logic [7:0]  sbq [$];
    logic [7:0]  exp_din [2];
    logic [15:0] exp_cnt [2];

    int checks;
    int errors;

    nvram_upload #(.ADDR_W(10), .SIZE(1024), .RAM_LAT(1), .INDEX(8'd4)) u_dut_l1 (
        .clk_4m(clk_4m), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
        .ioctl_addr(addr), .ioctl_index(index), .ioctl_din(din[0]), .ioctl_wait(wt[0]),
        .ram_addr(raddr[0]), .ram_rd(rrd[0]), .ram_q(rq[0]), .busy(bsy[0]),
        .done(dn[0]), .byte_cnt(bcnt[0])
    );

    nvram_upload #(.ADDR_W(10), .SIZE(1024), .RAM_LAT(3), .INDEX(8'd4)) u_dut_l3 (
        .clk_4m(clk_4m), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
        .ioctl_addr(addr), .ioctl_index(index), .ioctl_din(din[1]), .ioctl_wait(wt[1]),
        .ram_addr(raddr[1]), .ram_rd(rrd[1]), .ram_q(rq[1]), .busy(bsy[1]),
        .done(dn[1]), .byte_cnt(bcnt[1])
    );

    initial clk_4m = 1'b0;
    always #5 clk_4m = ~clk_4m;

    // RAM models: data appears RAM_LAT edges after ram_rd is sampled, filler otherwise.
    always @(posedge clk_4m) begin
        pipe0  <= rrd[0] ? mem[raddr[0]] : 8'h5A;
        pipe1a <= rrd[1] ? mem[raddr[1]] : 8'h5A;
        pipe1b <= pipe1a;
        pipe1c <= pipe1b;
    end
    assign rq[0] = pipe0;
    assign rq[1] = pipe1c;

    task automatic test_reset();
        int act [2];
        reset = 1'b1; upload = 1'b0; rd = 1'b0; addr = '0; index = 8'd0;
        act[0] = 0; act[1] = 0;
        repeat (3) @(posedge clk_4m);
        @(negedge clk_4m);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({din[d], wt[d], raddr[d], rrd[d], bsy[d], dn[d], bcnt[d]} !== 38'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %0h want 0", d,
                         {din[d], wt[d], raddr[d], rrd[d], bsy[d], dn[d], bcnt[d]});
            end
        end
        @(posedge clk_4m); #1 reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_4m); #1 rd = (c % 3 == 0);
            addr = 25'(c);
            @(negedge clk_4m);
            for (int d = 0; d < 2; d++)
                if (rrd[d] || wt[d] || bsy[d] || dn[d]) act[d]++;
        end
        rd = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== 0) begin
                errors++;
                $display("FAIL idle_rd_ignored dut%0d got %0d active cycles want 0", d, act[d]);
            end
        end
        exp_din[0] = 8'h00; exp_din[1] = 8'h00;
        exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;
    endtask

    task automatic start_session();
        @(posedge clk_4m); #1 index = 8'd4; upload = 1'b1;
        repeat (3) @(posedge clk_4m);
        @(negedge clk_4m);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bsy[d] !== 1'b1 || bcnt[d] !== 16'd0) begin
                errors++;
                $display("FAIL session_start dut%0d got busy=%0b cnt=%0d want busy=1 cnt=0",
                         d, bsy[d], bcnt[d]);
            end
            exp_cnt[d] = 16'd0;
        end
    endtask

    task automatic end_session();
        int dcnt [2];
        dcnt[0] = 0; dcnt[1] = 0;
        @(posedge clk_4m); #1 upload = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_4m);
            for (int d = 0; d < 2; d++) if (dn[d]) dcnt[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dcnt[d] !== 1 || bsy[d] !== 1'b0 || wt[d] !== 1'b0) begin
                errors++;
                $display("FAIL session_end dut%0d got done=%0d busy=%0b wait=%0b want 1 0 0",
                         d, dcnt[d], bsy[d], wt[d]);
            end
            checks++;
            if (bcnt[d] !== exp_cnt[d] || din[d] !== exp_din[d]) begin
                errors++;
                $display("FAIL end_hold dut%0d got cnt=%0d din=%0h want cnt=%0d din=%0h",
                         d, bcnt[d], din[d], exp_cnt[d], exp_din[d]);
            end
        end
    endtask

    task automatic do_read(input logic [24:0] a, input bit dup);
        logic [7:0]  exp_b;
        bit          inr;
        int          wcnt  [2];
        int          rcnt  [2];
        int          badrd [2];
        bit          fin   [2];
        logic [7:0]  got   [2];
        logic [15:0] gotc  [2];
        int          lat;
        inr   = (a < 25'd1024);
        exp_b = inr ? mem[a[9:0]] : 8'hFF;
        sbq.push_back(exp_b);
        for (int d = 0; d < 2; d++) begin
            wcnt[d] = 0; rcnt[d] = 0; badrd[d] = 0; fin[d] = 1'b0;
            got[d] = 8'h00; gotc[d] = 16'd0;
        end
        @(posedge clk_4m); #1 rd = 1'b1; addr = a;
        @(posedge clk_4m); #1 if (!dup) rd = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_4m);
            if (c == 2) rd = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!fin[d]) begin
                    if (rrd[d]) begin
                        rcnt[d]++;
                        if (c != 1 || raddr[d] !== a[9:0]) badrd[d]++;
                    end
                    if (wt[d] === 1'b1) wcnt[d]++;
                    else begin
                        fin[d]  = 1'b1;
                        got[d]  = din[d];
                        gotc[d] = bcnt[d];
                    end
                end
            end
        end
        exp_b = sbq.pop_front();
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            if (inr) exp_cnt[d] = exp_cnt[d] + 16'd1;
            exp_din[d] = exp_b;
            checks++;
            if (!fin[d]) begin
                errors++;
                $display("FAIL read_timeout dut%0d addr=%0h wait never dropped", d, a);
            end
            checks++;
            if (got[d] !== exp_b) begin
                errors++;
                $display("FAIL read_data dut%0d addr=%0h got %0h want %0h", d, a, got[d], exp_b);
            end
            checks++;
            if (wcnt[d] !== (inr ? lat : 1)) begin
                errors++;
                $display("FAIL wait_len dut%0d addr=%0h got %0d want %0d", d, a, wcnt[d],
                         inr ? lat : 1);
            end
            checks++;
            if (rcnt[d] !== (inr ? 1 : 0) || badrd[d] !== 0) begin
                errors++;
                $display("FAIL ram_rd dut%0d addr=%0h got %0d pulses %0d bad want %0d 0",
                         d, a, rcnt[d], badrd[d], inr ? 1 : 0);
            end
            checks++;
            if (gotc[d] !== exp_cnt[d]) begin
                errors++;
                $display("FAIL byte_cnt dut%0d addr=%0h got %0d want %0d", d, a, gotc[d], exp_cnt[d]);
            end
            checks++;
            if (din[d] !== exp_b) begin
                errors++;
                $display("FAIL din_hold dut%0d addr=%0h got %0h want %0h", d, a, din[d], exp_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) mem[i] = vals[i];
        start_session();
        for (int i = 0; i < 4; i++) do_read(25'(i), 1'b0);
    endtask

    task automatic test_out_of_range();
        do_read(25'd1024, 1'b0);
        do_read(25'h100005, 1'b0);
    endtask

    task automatic test_nomatch();
        int act [2];
        act[0] = 0; act[1] = 0;
        @(posedge clk_4m); #1 index = 8'd0; upload = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_4m); #1 rd = (c % 3 == 2);
            addr = 25'd5;
            @(negedge clk_4m);
            for (int d = 0; d < 2; d++)
                if (rrd[d] || wt[d] || bsy[d] || dn[d]) act[d]++;
        end
        rd = 1'b0;
        @(posedge clk_4m); #1 upload = 1'b0; index = 8'd4;
        repeat (3) @(posedge clk_4m);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act[d] !== 0) begin
                errors++;
                $display("FAIL nomatch_idle dut%0d got %0d active cycles want 0", d, act[d]);
            end
        end
    endtask

    task automatic test_drop_mid_read(input logic [24:0] a);
        int dcnt [2];
        dcnt[0] = 0; dcnt[1] = 0;
        @(posedge clk_4m); #1 rd = 1'b1; addr = a;
        @(posedge clk_4m); #1 rd = 1'b0;
        @(posedge clk_4m); #1 upload = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_4m);
            for (int d = 0; d < 2; d++) if (dn[d]) dcnt[d]++;
        end
        // LAT=1 finishes its read before the fall is seen; LAT=3 abandons it.
        exp_din[0] = mem[a[9:0]];
        exp_cnt[0] = exp_cnt[0] + 16'd1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dcnt[d] !== 1 || bsy[d] !== 1'b0 || wt[d] !== 1'b0) begin
                errors++;
                $display("FAIL drop_end dut%0d got done=%0d busy=%0b wait=%0b want 1 0 0",
                         d, dcnt[d], bsy[d], wt[d]);
            end
            checks++;
            if (din[d] !== exp_din[d] || bcnt[d] !== exp_cnt[d]) begin
                errors++;
                $display("FAIL drop_data dut%0d got din=%0h cnt=%0d want din=%0h cnt=%0d",
                         d, din[d], bcnt[d], exp_din[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int dcnt [2];
        dcnt[0] = 0; dcnt[1] = 0;
        start_session();
        @(posedge clk_4m); #1 rd = 1'b1; addr = 25'd7;
        @(posedge clk_4m); #1 rd = 1'b0;
        @(negedge clk_4m);
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({din[d], wt[d], raddr[d], rrd[d], bsy[d], dn[d], bcnt[d]} !== 38'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got %0h want 0", d,
                         {din[d], wt[d], raddr[d], rrd[d], bsy[d], dn[d], bcnt[d]});
            end
        end
        repeat (2) @(posedge clk_4m);
        #1 reset = 1'b0; upload = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_4m);
            for (int d = 0; d < 2; d++) if (dn[d]) dcnt[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dcnt[d] !== 0) begin
                errors++;
                $display("FAIL reset_no_done dut%0d got %0d done pulses want 0", d, dcnt[d]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[5] = 8'hA7;
        mem[6] = 8'h3C;
        mem[9] = 8'hE1;

        test_reset();

        start_session();
        do_read(25'd5, 1'b0);
        do_read(25'd6, 1'b1);
        end_session();

        test_back_to_back();
        test_out_of_range();
        end_session();

        test_nomatch();

        start_session();
        do_read(25'd3, 1'b0);
        test_drop_mid_read(25'd9);

        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Core-side responder for the host upload direction of the ioctl interface; the counterpart of the ROM download path that feeds dn_addr/dn_data/dn_wr.
- On a host upload request with a matching index, it reads bytes from the core's NVRAM/hiscore RAM port and returns them on ioctl_din.
- It stretches each read with ioctl_wait until the byte is valid.
- It raises busy so the core arbiter yields the RAM port for the duration.

Parameters:
- ADDR_W, 10, width of the RAM address bus.
- SIZE, 1024, number of valid bytes; legal addresses are 0..SIZE-1 (SIZE <= 2**ADDR_W).
- RAM_LAT, 1, cycles from ram_rd to valid ram_q (1..3).
- INDEX, 8'd4, ioctl_index value this block answers.

Ports:
- clk_4m  in  1  core clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  host upload session active (level).
- ioctl_rd  in  1  host read strobe, one-cycle pulse.
- ioctl_addr  in  25  host byte address, sampled with ioctl_rd.
- ioctl_index  in  8  upload target selector.
- ioctl_din  out  8  byte returned to the host.
- ioctl_wait  out  1  high while the requested byte is not yet valid.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  RAM read enable, one-cycle pulse.
- ram_q  in  8  RAM read data.
- busy  out  1  upload session owns the RAM port.
- done  out  1  one-cycle pulse at session end.
- byte_cnt  out  16  in-range bytes delivered this session; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; ioctl_din=8'h00; ioctl_wait=0; ram_addr=0; ram_rd=0; busy=0; done=0; byte_cnt=0.
  - Asserting reset mid-read aborts the read immediately; no done pulse is generated.
- Session start: ioctl_upload and index_match are registered internally.
  - IDLE -> ARMED on the first cycle the registered ioctl_upload is 1 and the registered index_match is 1 (rising edge of the upload qualifier).
  - On that transition: busy=1, byte_cnt=0.
  - An upload with a non-matching index leaves the block in IDLE with all outputs idle.
- ARMED, ioctl_rd sampled high in cycle N:
  - In-range (ioctl_addr < SIZE):
    - Cycle N+1: ram_addr=ioctl_addr[ADDR_W-1:0], ram_rd=1 for one cycle, ioctl_wait=1; state=READ.
    - A RAM_LAT-cycle counter runs; ram_q is captured at cycle N+1+RAM_LAT.
    - At capture: ioctl_din=ram_q, ioctl_wait=0 in the same cycle, byte_cnt += 1 (saturating); state=ARMED.
    - Total: ioctl_wait is high for exactly RAM_LAT cycles.
  - Out-of-range (ioctl_addr >= SIZE, including any nonzero upper bits):
    - Cycle N+1: ioctl_din=8'hFF, ioctl_wait=1 for exactly one cycle; no ram_rd; byte_cnt unchanged.
- ioctl_rd while ioctl_wait=1 (state READ) is ignored; no request is queued.
- ioctl_rd in IDLE is ignored.
- ioctl_din holds its last value between reads and after the session ends.
- Session end: registered ioctl_upload falls while in ARMED or READ.
  - Next cycle: state=IDLE, busy=0, done=1 for one cycle, ioctl_wait=0.
  - Any in-flight RAM read is abandoned; ioctl_din is not updated by it.
  - byte_cnt holds its value until the next session starts.
- ioctl_index changing mid-session has no effect; the index is qualified only at session start.
- Simultaneous events:
  - Upload fall and ioctl_rd in the same cycle: the fall wins, and the read is not serviced.
  - Upload fall and the capture cycle in the same cycle: the capture completes (ioctl_din and byte_cnt update), then the block ends the session normally.
- ram_rd is never high in IDLE; ram_rd is never high on two consecutive cycles.

Test Plan:
- Reset, then IDLE with upload=0 -> all outputs 0; ioctl_rd pulses produce no ram_rd and no wait.
- RAM_LAT=1, index=4, upload rises, RAM[0x005]=8'hA7, rd at addr 5 -> ram_rd and ram_addr=5 at N+1; wait high 1 cycle; ioctl_din=8'hA7; byte_cnt=1.
- RAM_LAT=3, read addrs 0..3 holding 11,22,33,44 -> each read holds wait for 3 cycles; ioctl_din returns the values in order; byte_cnt=4.
- Out-of-range: rd at addr 1024, then at 25'h100005 -> ioctl_din=8'hFF, wait for 1 cycle each; no ram_rd; byte_cnt unchanged.
- Upload drop mid-read (RAM_LAT=3, drop 1 cycle after ram_rd) -> wait=0 next cycle, done=1 for one cycle, busy=0; ioctl_din keeps its prior value.
- Non-matching index (8'd0) with upload=1 and rd pulses -> busy stays 0 and no RAM activity; asynchronous reset during READ -> outputs zero immediately with no done pulse.
